// File: rtl/seg7_pkg.sv
// Shared types and hex glyph table for the multiplexed 7-segment driver.
// Glyphs are active-high {a,b,c,d,e,f,g}; pin polarity is applied at the top.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {
    IDLE_GUARD = 1'b0,
    LIT        = 1'b1
  } scan_state_e;

  localparam seg7_t SEG_0     = 7'b1111110;
  localparam seg7_t SEG_1     = 7'b0110000;
  localparam seg7_t SEG_2     = 7'b1101101;
  localparam seg7_t SEG_3     = 7'b1111001;
  localparam seg7_t SEG_4     = 7'b0110011;
  localparam seg7_t SEG_5     = 7'b1011011;
  localparam seg7_t SEG_6     = 7'b1011111;
  localparam seg7_t SEG_7     = 7'b1110000;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1111011;
  localparam seg7_t SEG_A     = 7'b1110111;
  localparam seg7_t SEG_B     = 7'b0011111;
  localparam seg7_t SEG_C     = 7'b1001110;
  localparam seg7_t SEG_D     = 7'b0111101;
  localparam seg7_t SEG_E     = 7'b1001111;
  localparam seg7_t SEG_F     = 7'b1000111;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  function automatic seg7_t hex_glyph(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decode with blanking; active-high segments.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] glyph_c
);

  always_comb begin
    glyph_c = hex_glyph(nibble);
    if (blank) glyph_c = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: refresh counter, digit scan,
// shadow/shown double buffer with frame-aligned update, registered pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned DIGIT_HZ       = 1000,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic                    pending,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int unsigned TICKS = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    TICK_LAST  = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0]    GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam scan_state_e         DWELL_START = (GUARD > 0) ? IDLE_GUARD : LIT;
  localparam logic [6:0]          SEG_OFF    = SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
  localparam logic                DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF     = {N_DIGITS{AN_ACTIVE_LOW}};

  if (N_DIGITS == 0 || DIGIT_HZ == 0 || TICKS < 2 || GUARD >= TICKS) begin : g_param_check
    $error("seg7_scan_driver: illegal parameters (need N_DIGITS>=1, TICKS>=2, GUARD<TICKS)");
  end

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*N_DIGITS-1:0]   shown_val_q, shown_val_d;
  logic [N_DIGITS-1:0]     shown_dp_q, shown_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    dwell_end_c, frame_edge_c;
  logic [3:0]              cur_nib_c;
  logic                    cur_dp_c, cur_en_c, cur_lz_c, zero_run_c, lit_c;
  logic [N_DIGITS-1:0]     an_sel_c;
  logic [6:0]              glyph_c;

  assign dwell_end_c  = (cnt_q == TICK_LAST);
  assign frame_edge_c = dwell_end_c && (idx_q == IDX_LAST);

  // Select the scanned digit; zero_run tracks "all nibbles from here up are zero".
  always_comb begin
    cur_nib_c  = 4'd0;
    cur_dp_c   = 1'b0;
    cur_en_c   = 1'b0;
    cur_lz_c   = 1'b0;
    zero_run_c = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (shown_val_q[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib_c = shown_val_q[4*i +: 4];
        cur_dp_c  = shown_dp_q[i];
        cur_en_c  = digit_en[i];
        cur_lz_c  = zero_run_c && (i != 0);
      end
    end
    lit_c = (state_q == LIT) && cur_en_c && !(lz_blank && cur_lz_c);
    for (int i = 0; i < N_DIGITS; i++) begin
      an_sel_c[i] = lit_c && (idx_q == IDX_W'(i));
    end
  end

  seg7_glyph u_glyph (
    .nibble  (cur_nib_c),
    .blank   (!lit_c),
    .glyph_c (glyph_c)
  );

  // Scan FSM, refresh counter, load handshake and output next-state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    shown_val_d  = shown_val_q;
    shown_dp_d   = shown_dp_q;
    pending_d    = pending_q;

    if (dwell_end_c) begin
      cnt_d   = '0;
      state_d = DWELL_START;
      idx_d   = frame_edge_c ? '0 : idx_q + IDX_W'(1);
    end else if (state_q == IDLE_GUARD && cnt_q == GUARD_LAST) begin
      state_d = LIT;
    end

    if (frame_edge_c) begin
      if (load) begin
        shown_val_d = value;
        shown_dp_d  = dp_in;
      end else if (pending_q) begin
        shown_val_d = shadow_val_q;
        shown_dp_d  = shadow_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    seg_d        = glyph_c ^ {7{SEG_ACTIVE_LOW}};
    dp_d         = (lit_c && cur_dp_c) ^ SEG_ACTIVE_LOW;
    an_d         = an_sel_c ^ AN_OFF;
    frame_done_d = frame_edge_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DWELL_START;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shown_val_q  <= '0;
      shown_dp_q   <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shown_val_q  <= shown_val_d;
      shown_dp_q   <= shown_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pending    = pending_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4 cycles per dwell, 1 guard cycle,
// active-low segments and anodes. Expected glyphs are hand-inverted constants.
module tb_seg7_scan_driver;

  localparam logic [6:0] G_0   = 7'b0000001;
  localparam logic [6:0] G_1   = 7'b1001111;
  localparam logic [6:0] G_2   = 7'b0010010;
  localparam logic [6:0] G_3   = 7'b0000110;
  localparam logic [6:0] G_4   = 7'b1001100;
  localparam logic [6:0] G_5   = 7'b0100100;
  localparam logic [6:0] G_6   = 7'b0100000;
  localparam logic [6:0] G_7   = 7'b0001111;
  localparam logic [6:0] G_8   = 7'b0000000;
  localparam logic [6:0] G_9   = 7'b0000100;
  localparam logic [6:0] G_A   = 7'b0001000;
  localparam logic [6:0] G_B   = 7'b1100000;
  localparam logic [6:0] G_C   = 7'b0110001;
  localparam logic [6:0] G_D   = 7'b1000010;
  localparam logic [6:0] G_OFF = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic        load;
  logic        pending;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int          n_checks;
  int          n_pass;
  int          cyc;
  logic [6:0]  glyphs [4];

  seg7_scan_driver #(
    .N_DIGITS       (4),
    .CLK_HZ         (8),
    .DIGIT_HZ       (2),
    .GUARD          (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .load       (load),
    .pending    (pending),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_glyphs(input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0);
    glyphs[3] = d3;
    glyphs[2] = d2;
    glyphs[1] = d1;
    glyphs[0] = d0;
  endtask

  // Step n cycles; digit d lights in dwell positions 1..3 when lit[d] is set.
  task automatic scan(input int n, input logic [3:0] lit, input logic [3:0] dpm, input logic pend);
    int         pos;
    logic [1:0] di;
    logic       on;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    for (int k = 0; k < n; k++) begin
      step();
      load    = 1'b0;
      pos     = (cyc - 1) % 4;
      di      = 2'((cyc - 1) / 4);
      on      = (pos != 0) && lit[di];
      exp_an  = on ? ~(4'b0001 << di) : 4'b1111;
      exp_seg = on ? glyphs[di] : G_OFF;
      exp_dp  = !(on && dpm[di]);
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("frame_done", 32'(frame_done), 32'((cyc % 16) == 0));
      check("pending", 32'(pending), 32'(pend));
    end
  endtask

  task automatic check_reset_state();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(G_OFF));
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    reset    = 1'b1;
    value    = 16'h0000;
    dp_in    = 4'b0000;
    digit_en = 4'b1111;
    lz_blank = 1'b0;
    load     = 1'b0;
    set_glyphs(G_0, G_0, G_0, G_0);

    repeat (3) step();
    check_reset_state();
    reset = 1'b0;
    cyc   = 0;

    // Free-running scan of the reset contents
    scan(16, 4'b1111, 4'b0000, 1'b0);

    // Mid-frame load waits for the frame edge
    value = 16'h1234;
    load  = 1'b1;
    scan(15, 4'b1111, 4'b0000, 1'b1);
    scan(1, 4'b1111, 4'b0000, 1'b0);
    set_glyphs(G_1, G_2, G_3, G_4);
    scan(31, 4'b1111, 4'b0000, 1'b0);

    // Load on the frame edge bypasses the shadow
    value = 16'hABCD;
    load  = 1'b1;
    scan(1, 4'b1111, 4'b0000, 1'b0);
    set_glyphs(G_A, G_B, G_C, G_D);
    scan(16, 4'b1111, 4'b0000, 1'b0);

    // Leading-zero blanking
    value    = 16'h0050;
    lz_blank = 1'b1;
    load     = 1'b1;
    scan(15, 4'b1111, 4'b0000, 1'b1);
    scan(1, 4'b1111, 4'b0000, 1'b0);
    set_glyphs(G_OFF, G_OFF, G_5, G_0);
    scan(16, 4'b0011, 4'b0000, 1'b0);
    value = 16'h0000;
    load  = 1'b1;
    scan(15, 4'b0011, 4'b0000, 1'b1);
    scan(1, 4'b0011, 4'b0000, 1'b0);
    set_glyphs(G_OFF, G_OFF, G_OFF, G_0);
    scan(16, 4'b0001, 4'b0000, 1'b0);

    // Per-digit enable (live) and decimal point (latched with value)
    lz_blank = 1'b0;
    digit_en = 4'b0101;
    value    = 16'h9876;
    dp_in    = 4'b0001;
    load     = 1'b1;
    set_glyphs(G_0, G_0, G_0, G_0);
    scan(15, 4'b0101, 4'b0000, 1'b1);
    scan(1, 4'b0101, 4'b0000, 1'b0);
    set_glyphs(G_9, G_8, G_7, G_6);
    scan(16, 4'b0101, 4'b0001, 1'b0);

    // Reset mid-dwell with a pending load
    value = 16'h1111;
    dp_in = 4'b0000;
    load  = 1'b1;
    scan(2, 4'b0101, 4'b0001, 1'b1);
    reset = 1'b1;
    step();
    check_reset_state();
    reset = 1'b0;
    cyc   = 0;
    set_glyphs(G_0, G_0, G_0, G_0);
    scan(16, 4'b0101, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
